// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue feeding decode over valid/ready.
// Optional stall/redirect statistics counters are built only when FETCH_STATS_EN is defined.
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     PCsrcEx,
  input  logic [XLEN-1:0]          PCtrgEx,
  output logic [XLEN-1:0]          imem_addr,
  output logic                     imem_en,
  input  logic [XLEN-1:0]          imem_rdata,
  output logic [XLEN-1:0]          InstrDe,
  output logic [XLEN-1:0]          PCDe,
  output logic [XLEN-1:0]          PCplus4De,
  output logic                     ValidDe,
  input  logic                     ReadyDe,
  output logic [$clog2(DEPTH):0]   CountFe,
  output logic [15:0]              StallCntFe,
  output logic [15:0]              FlushCntFe
);

  localparam int              PW   = $clog2(DEPTH);
  localparam logic [XLEN-1:0] INC  = XLEN'(PC_INC);
  localparam logic [PW:0]     FULL = (PW+1)'(DEPTH);

  logic [XLEN-1:0] pcReg;
  logic [XLEN-1:0] instrBuf  [DEPTH];
  logic [XLEN-1:0] pcBuf     [DEPTH];
  logic [XLEN-1:0] pcNextBuf [DEPTH];
  logic [PW-1:0]   rdPtr;
  logic [PW-1:0]   wrPtr;
  logic [PW:0]     count;
  logic            full;
  logic            valid;
  logic            pop;
  logic            enq;
  logic [XLEN-1:0] enqPc;
  logic [XLEN-1:0] enqPcNext;

  // A redirect always fetches from the target, so the enqueue path follows imem_addr.
  always_comb begin
    full      = (count == FULL);
    valid     = (count != '0) && !PCsrcEx;
    pop       = valid && ReadyDe;
    enq       = PCsrcEx || !full || pop;
    enqPc     = PCsrcEx ? PCtrgEx : pcReg;
    enqPcNext = enqPc + INC;
  end

  assign imem_addr = enqPc;
  assign imem_en   = enq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcReg <= RESET_PC;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (PCsrcEx) begin
      // Flush by moving the head onto the slot being written this cycle.
      pcReg <= enqPcNext;
      rdPtr <= wrPtr;
      wrPtr <= wrPtr + 1'b1;
      count <= (PW+1)'(1);
    end else begin
      if (enq) begin
        pcReg <= enqPcNext;
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (enq && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !enq) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      instrBuf[wrPtr]  <= imem_rdata;
      pcBuf[wrPtr]     <= enqPc;
      pcNextBuf[wrPtr] <= enqPcNext;
    end
  end

  assign ValidDe   = valid;
  assign InstrDe   = valid ? instrBuf[rdPtr]  : '0;
  assign PCDe      = valid ? pcBuf[rdPtr]     : '0;
  assign PCplus4De = valid ? pcNextBuf[rdPtr] : '0;
  assign CountFe   = count;

`ifdef FETCH_STATS_EN
  logic [15:0] stallCnt;
  logic [15:0] flushCnt;

  // Saturating counters: full-queue stalls and redirect cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (!PCsrcEx && full && !pop && (stallCnt != 16'hFFFF)) begin
        stallCnt <= stallCnt + 16'd1;
      end
      if (PCsrcEx && (flushCnt != 16'hFFFF)) begin
        flushCnt <= flushCnt + 16'd1;
      end
    end
  end

  assign StallCntFe = stallCnt;
  assign FlushCntFe = flushCnt;
`else
  assign StallCntFe = '0;
  assign FlushCntFe = '0;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: directed stimulus pushes expected decode entries,
// a negedge monitor pops and compares on every ValidDe&ReadyDe transfer.
module tb_fetch_queue_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcNext;
  } entry_t;

`ifdef FETCH_STATS_EN
  localparam int statsOn = 1;
`else
  localparam int statsOn = 0;
`endif

  logic        clk;
  logic        rst;
  logic        PCsrcEx;
  logic [31:0] PCtrgEx;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] InstrDe;
  logic [31:0] PCDe;
  logic [31:0] PCplus4De;
  logic        ValidDe;
  logic        ReadyDe;
  logic [2:0]  CountFe;
  logic [15:0] StallCntFe;
  logic [15:0] FlushCntFe;

  entry_t expQ[$];
  int     checks = 0;
  int     errors = 0;

  fetch_queue_stage #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_INC(4)
  ) dut (
    .clk(clk), .rst(rst), .PCsrcEx(PCsrcEx), .PCtrgEx(PCtrgEx),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .InstrDe(InstrDe), .PCDe(PCDe), .PCplus4De(PCplus4De),
    .ValidDe(ValidDe), .ReadyDe(ReadyDe), .CountFe(CountFe),
    .StallCntFe(StallCntFe), .FlushCntFe(FlushCntFe)
  );

  assign imem_rdata = imem_addr ^ 32'hA5A5A5A5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic rdy, input logic src, input logic [31:0] trg);
    rst     = r;
    ReadyDe = rdy;
    PCsrcEx = src;
    PCtrgEx = trg;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expectEntry(input logic [31:0] i, input logic [31:0] p, input logic [31:0] n);
    entry_t e;
    e.instr  = i;
    e.pc     = p;
    e.pcNext = n;
    expQ.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    entry_t e;
    if (rst && ValidDe && ReadyDe) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL transfer unexpected got pc=%h expected none", PCDe);
      end else begin
        e = expQ.pop_front();
        if ({InstrDe, PCDe, PCplus4De} !== {e.instr, e.pc, e.pcNext}) begin
          errors++;
          $display("[TB] FAIL transfer got %h/%h/%h expected %h/%h/%h",
                   InstrDe, PCDe, PCplus4De, e.instr, e.pc, e.pcNext);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectEntry(32'hA5A5A5A5, 32'h0000_0000, 32'h0000_0004);
    expectEntry(32'hA5A5A5A1, 32'h0000_0004, 32'h0000_0008);
    expectEntry(32'hA5A5A5AD, 32'h0000_0008, 32'h0000_000C);
    expectEntry(32'hA5A5A5A9, 32'h0000_000C, 32'h0000_0010);
    expectEntry(32'hA5A5A5B5, 32'h0000_0010, 32'h0000_0014);
    expectEntry(32'hA5A5A5B1, 32'h0000_0014, 32'h0000_0018);
    expectEntry(32'hA5A5A5BD, 32'h0000_0018, 32'h0000_001C);
    expectEntry(32'hA5A5A5B9, 32'h0000_001C, 32'h0000_0020);
    expectEntry(32'hA5A5A585, 32'h0000_0020, 32'h0000_0024);
    expectEntry(32'hA5A5A4A5, 32'h0000_0100, 32'h0000_0104);
    expectEntry(32'hA5A5A4A1, 32'h0000_0104, 32'h0000_0108);
    expectEntry(32'h5A5A5A59, 32'hFFFF_FFFC, 32'h0000_0000);
    expectEntry(32'hA5A5A5A5, 32'h0000_0000, 32'h0000_0004);

    @(negedge clk);
    checkOutput("resetValid", 32'(ValidDe), 32'd0);
    checkOutput("resetCount", 32'(CountFe), 32'd0);
    checkOutput("resetPCDe", PCDe, 32'h0);
    checkOutput("resetInstr", InstrDe, 32'h0);
    checkOutput("resetPCplus4", PCplus4De, 32'h0);
    checkOutput("resetAddr", imem_addr, 32'h0);

    nextCycle(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    nextCycle(); @(negedge clk);
    checkOutput("firstValid", 32'(ValidDe), 32'd1);
    checkOutput("firstCount", 32'(CountFe), 32'd1);
    nextCycle(); @(negedge clk);
    checkOutput("steadyCount", 32'(CountFe), 32'd1);
    nextCycle(); nextCycle();

    nextCycle(); applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle(); nextCycle(); nextCycle(); @(negedge clk);
    checkOutput("fullCount", 32'(CountFe), 32'd4);
    checkOutput("fullImemEn", 32'(imem_en), 32'd0);
    nextCycle(); nextCycle();

    nextCycle(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) nextCycle();
      @(negedge clk);
      checkOutput("drainValid", 32'(ValidDe), 32'd1);
      checkOutput("drainCount", 32'(CountFe), 32'd4);
    end

    nextCycle(); applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
    @(negedge clk);
    checkOutput("redirValid", 32'(ValidDe), 32'd0);
    checkOutput("redirImemEn", 32'(imem_en), 32'd1);
    checkOutput("redirAddr", imem_addr, 32'h100);
    nextCycle(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("postRedirCount", 32'(CountFe), 32'd1);
    checkOutput("postRedirPCplus4", PCplus4De, 32'h104);
    checkOutput("postRedirAddr", imem_addr, 32'h104);
    nextCycle();

    nextCycle(); applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    @(negedge clk);
    checkOutput("wrapRedirValid", 32'(ValidDe), 32'd0);
    nextCycle(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("wrapPCplus4", PCplus4De, 32'h0);
    nextCycle(); @(negedge clk);
    checkOutput("wrapNextPC", PCDe, 32'h0);

    nextCycle(); applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle(); nextCycle(); @(negedge clk);
    checkOutput("preResetCount", 32'(CountFe), 32'd3);
    checkOutput("preResetStall", 32'(StallCntFe), (statsOn != 0) ? 32'd3 : 32'd0);
    checkOutput("preResetFlush", 32'(FlushCntFe), (statsOn != 0) ? 32'd2 : 32'd0);
    #1 rst = 1'b0;
    #1;
    checkOutput("midResetCount", 32'(CountFe), 32'd0);
    checkOutput("midResetValid", 32'(ValidDe), 32'd0);
    checkOutput("midResetPCDe", PCDe, 32'h0);
    checkOutput("midResetAddr", imem_addr, 32'h0);
    checkOutput("midResetStall", 32'(StallCntFe), 32'd0);
    checkOutput("queueDrained1", 32'(expQ.size()), 32'd0);

    expectEntry(32'hA5A5A5A5, 32'h0000_0000, 32'h0000_0004);
    expectEntry(32'hA5A5A5A1, 32'h0000_0004, 32'h0000_0008);
    expectEntry(32'hA5A5A5AD, 32'h0000_0008, 32'h0000_000C);
    expectEntry(32'hA5A5A5A9, 32'h0000_000C, 32'h0000_0010);
    expectEntry(32'hA5A5A6A5, 32'h0000_0300, 32'h0000_0304);
    expectEntry(32'hA5A5A6A1, 32'h0000_0304, 32'h0000_0308);

    nextCycle(); applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (4) nextCycle();
    @(negedge clk);
    checkOutput("refillCount", 32'(CountFe), 32'd4);
    repeat (10) nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("stallCount", 32'(StallCntFe), (statsOn != 0) ? 32'd10 : 32'd0);
    repeat (3) nextCycle();

    nextCycle(); applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
    nextCycle(); applyStimulus(1'b1, 1'b1, 1'b1, 32'h300);
    @(negedge clk);
    checkOutput("doubleRedirValid", 32'(ValidDe), 32'd0);
    nextCycle(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("flushCount", 32'(FlushCntFe), (statsOn != 0) ? 32'd2 : 32'd0);
    checkOutput("stallHeld", 32'(StallCntFe), (statsOn != 0) ? 32'd10 : 32'd0);
    nextCycle();
    nextCycle(); applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("queueDrained2", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
# fetch_queue_stage

Parametrised instruction fetch stage with a prefetch queue. Holds the program counter, reads an external instruction memory and buffers up to DEPTH fetched entries {instruction, PC, PC+4}. It delivers these entries to decode over a valid/ready handshake. It sits between the PC-redirect source in execute (PCsrcEx/PCtrgEx) and the decode stage, and decouples fetch from decode stalls.

## Interface
- XLEN, 32: PC and instruction width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: PC value loaded on reset.
- PC_INC, 4: sequential PC increment.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- PCsrcEx  in  1  redirect request from execute.
- PCtrgEx  in  XLEN  redirect target.
- imem_addr  out  XLEN  instruction memory address; combinational read.
- imem_en  out  1  fetch strobe; high when a fetched word is enqueued this cycle.
- imem_rdata  in  XLEN  instruction read at imem_addr, same cycle.
- InstrDe  out  XLEN  head instruction.
- PCDe  out  XLEN  head PC.
- PCplus4De  out  XLEN  head PC+PC_INC.
- ValidDe  out  1  head entry valid.
- ReadyDe  in  1  decode accepts head.
- CountFe  out  $clog2(DEPTH)+1  entries held.
- StallCntFe  out  16  full-stall cycle counter (see Configuration).
- FlushCntFe  out  16  redirect counter (see Configuration).

## Operation
- State: PC register; circular buffer with rd_ptr/wr_ptr (mod DEPTH); count 0..DEPTH.
- imem_addr = PCsrcEx ? PCtrgEx : PC.
- pop = ValidDe & ReadyDe.
- ValidDe = (count≠0) & ~PCsrcEx. A redirect cycle never transfers an entry.
- InstrDe/PCDe/PCplus4De = head entry fields when ValidDe, else all zero.
- Redirect cycle (PCsrcEx=1), highest priority:
  - Discard all entries.
  - Write {imem_rdata, PCtrgEx, PCtrgEx+PC_INC} as the sole entry; count←1.
  - PC←PCtrgEx+PC_INC; imem_en=1.
- Normal cycle, imem_en = (count<DEPTH) | pop:
  - If imem_en: enqueue {imem_rdata, PC, PC+PC_INC}; PC←PC+PC_INC.
  - Otherwise PC holds.
- Count update: enqueue&~pop +1; pop&~enqueue −1; both or neither unchanged.
- Full and pop in the same cycle: enqueue and dequeue together; count stays DEPTH, no bubble.
- Empty and enqueue: the entry becomes visible the next cycle. There is no same-cycle bypass.
- Arithmetic: PC+PC_INC is modulo 2^XLEN, so 0xFFFFFFFC+4 wraps to 0. Pointers wrap modulo DEPTH.

## Timing
- Reset (rst=0, asynchronous):
  - PC=RESET_PC; count=0; pointers=0; counters=0.
  - ValidDe=0; InstrDe/PCDe/PCplus4De=0; CountFe=0.
  - imem_addr=RESET_PC.
- First edge after release: RESET_PC entry enqueued. ValidDe=1 from cycle 1.
- Steady state with ReadyDe=1: one entry per cycle, count holds at 1.
- Redirect in cycle N: the target entry is presented with ValidDe=1 in cycle N+1. Redirect penalty is one cycle with ValidDe=0 (cycle N).
- ReadyDe=0: queue fills in DEPTH cycles. imem_en drops when count=DEPTH and ReadyDe=0.
- Reset asserted mid-operation: all state clears immediately; queued entries are lost.

## Configuration
- FETCH_STATS_EN defined:
  - StallCntFe increments each cycle with ~PCsrcEx & count=DEPTH & ~pop.
  - FlushCntFe increments each cycle with PCsrcEx=1.
  - Both saturate at 0xFFFF and clear on reset.
- FETCH_STATS_EN undefined: both ports tied to 0 and no counter logic is generated. Other behaviour is identical.

## Test plan
- Reset release, imem_rdata=addr^0xA5A5A5A5, ReadyDe=1 -> cycle 1: ValidDe=1, PCDe=0, PCplus4De=4, InstrDe=0xA5A5A5A5. Subsequent PCs 4, 8, 12 on consecutive cycles; CountFe=1.
- ReadyDe=0 for 6 cycles, DEPTH=4 -> CountFe reaches 4 and imem_en=0. Release ReadyDe: entries PC 0,4,8,12 in order with no bubble, then 16.
- Full queue with PCsrcEx=1, PCtrgEx=0x100 -> ValidDe=0 that cycle. Next cycle: CountFe=1, PCDe=0x100, PCplus4De=0x104. Following fetch at 0x104.
- Redirect to 0xFFFFFFFC -> PCplus4De=0; next entry PCDe=0.
- rst pulsed low mid-stream with 3 entries queued -> outputs and CountFe zero immediately; after release, refetch from RESET_PC.
- With FETCH_STATS_EN: 10 full-stall cycles and 2 redirects -> StallCntFe=10, FlushCntFe=2. Without the macro: both read 0.
